// File: rtl/cam_pkg.sv
// Shared types and constants for the camera line DMA.
package cam_pkg;

    // Line-copy FSM states.
    typedef enum logic [3:0] {
        StIdle,
        StArm,
        StPoll,
        StPollWait,
        StRd,
        StRdWait,
        StWr,
        StNext,
        StDisarm
    } state_t;

    // Camera controller register map.
    localparam logic [10:0] CTRL_ADDR   = 11'd1281;
    localparam logic [10:0] STATUS_ADDR = 11'd1282;

    // Status register layout: [10] capture active, [9:0] hsync count.
    localparam int unsigned STATUS_CAPTURE_BIT = 10;
    localparam int unsigned HCNT_W             = 10;

    // Pixel occupies readdata[31:8].
    localparam int unsigned PIXEL_LSB = 8;

    // Frame buffer word: 24-bit pixel zero-extended to 32 bits.
    function automatic logic [31:0] pixel_to_fb(input logic [23:0] pixel);
        return {8'h00, pixel};
    endfunction

endpackage

// File: rtl/cam_line_addr_gen.sv
// Pixel/line counters and the ping-pong buffer and frame buffer address generators.
module cam_line_addr_gen
    import cam_pkg::*;
#(
    parameter int unsigned LINE_WIDTH   = 640,
    parameter int unsigned BUF_B_OFFSET = 640
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                frame_start,
    input  logic [31:0]         frame_base,
    input  logic                line_load,
    input  logic [HCNT_W-1:0]   line_sel,
    input  logic                px_inc,
    input  logic                line_inc,
    output logic                px_last,
    output logic [HCNT_W-1:0]   lines_done,
    output logic [10:0]         buf_addr,
    output logic [31:0]         fb_addr
);

    logic [31:0]       base_q;
    logic [HCNT_W-1:0] line_q;
    logic [10:0]       px_q;

    // Latch base per frame, track the line being copied and the pixel within it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            base_q     <= 32'd0;
            line_q     <= '0;
            px_q       <= 11'd0;
            lines_done <= '0;
        end else begin
            if (frame_start) begin
                base_q     <= frame_base;
                lines_done <= '0;
            end else if (line_inc) begin
                lines_done <= lines_done + 1'b1;
            end
            if (line_load) begin
                line_q <= line_sel;
                px_q   <= 11'd0;
            end else if (px_inc) begin
                px_q <= px_q + 11'd1;
            end
        end
    end

    // Odd lines live in buffer B; frame buffer address wraps mod 2^32.
    always_comb begin
        px_last  = (px_q == 11'(LINE_WIDTH - 1));
        buf_addr = (line_q[0] ? 11'(BUF_B_OFFSET) : 11'd0) + px_q;
        fb_addr  = base_q + ((32'(line_q) * LINE_WIDTH + 32'(px_q)) << 2);
    end

endmodule

// File: rtl/cam_line_dma.sv
// Camera line DMA: polls the controller, copies completed lines into a linear frame buffer.
// Optional feature macro: CAM_LINE_DMA_OVERRUN_EN adds overrun_count[15:0].
module cam_line_dma
    import cam_pkg::*;
#(
    parameter int unsigned LINE_WIDTH   = 640,
    parameter int unsigned FRAME_LINES  = 480,
    parameter int unsigned BUF_B_OFFSET = 640
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [31:0]       frame_base,
    output logic              busy,
    output logic              done,
    output logic [9:0]        lines_done,
    output logic [10:0]       cam_address,
    output logic              cam_read,
    input  logic [31:0]       cam_readdata,
    output logic              cam_write,
    output logic [31:0]       cam_writedata,
    output logic [31:0]       fb_address,
    output logic              fb_write,
    output logic [31:0]       fb_writedata,
`ifdef CAM_LINE_DMA_OVERRUN_EN
    output logic [15:0]       overrun_count,
`endif
    input  logic              fb_waitrequest
);

    state_t            state_q;
    logic [HCNT_W-1:0] last_hcnt_q;

    logic              capture;
    logic [HCNT_W-1:0] hcnt;
    logic              line_evt;
    logic [HCNT_W-1:0] line_sel;
    logic              frame_start;
    logic              evt_take;
    logic              px_inc;
    logic              line_inc;
    logic              px_last;
    logic              last_line;
    logic [10:0]       buf_addr;
    logic [31:0]       fb_addr;

    // Decode the status word and the per-cycle counter controls.
    always_comb begin
        capture     = cam_readdata[STATUS_CAPTURE_BIT];
        hcnt        = cam_readdata[HCNT_W-1:0];
        line_evt    = capture && (hcnt != last_hcnt_q);
        // A backwards hcnt is a new frame: the line just finished is last_hcnt.
        line_sel    = (hcnt < last_hcnt_q) ? last_hcnt_q : hcnt - 10'd1;
        frame_start = (state_q == StIdle) && start;
        evt_take    = (state_q == StPollWait) && line_evt;
        px_inc      = (state_q == StWr) && !fb_waitrequest;
        line_inc    = (state_q == StNext);
        last_line   = ((lines_done + 10'd1) == 10'(FRAME_LINES));
    end

    cam_line_addr_gen #(
        .LINE_WIDTH   (LINE_WIDTH),
        .BUF_B_OFFSET (BUF_B_OFFSET)
    ) u_addr_gen (
        .clk         (clk),
        .reset       (reset),
        .frame_start (frame_start),
        .frame_base  (frame_base),
        .line_load   (evt_take),
        .line_sel    (line_sel),
        .px_inc      (px_inc),
        .line_inc    (line_inc),
        .px_last     (px_last),
        .lines_done  (lines_done),
        .buf_addr    (buf_addr),
        .fb_addr     (fb_addr)
    );

    // Main FSM; strobes are registered so they line up with the state they belong to.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= StIdle;
            busy          <= 1'b0;
            done          <= 1'b0;
            cam_read      <= 1'b0;
            cam_write     <= 1'b0;
            cam_writedata <= 32'd0;
            fb_write      <= 1'b0;
            fb_writedata  <= 32'd0;
            last_hcnt_q   <= '0;
        end else begin
            done      <= 1'b0;
            cam_read  <= 1'b0;
            cam_write <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (start) begin
                        busy          <= 1'b1;
                        last_hcnt_q   <= '0;
                        cam_write     <= 1'b1;
                        cam_writedata <= 32'd1;
                        state_q       <= StArm;
                    end
                end
                StArm: begin
                    cam_read <= 1'b1;
                    state_q  <= StPoll;
                end
                StPoll: state_q <= StPollWait;
                StPollWait: begin
                    cam_read <= 1'b1;
                    if (line_evt) begin
                        last_hcnt_q <= hcnt;
                        state_q     <= StRd;
                    end else begin
                        state_q <= StPoll;
                    end
                end
                StRd: state_q <= StRdWait;
                StRdWait: begin
                    fb_write     <= 1'b1;
                    fb_writedata <= pixel_to_fb(cam_readdata[31:PIXEL_LSB]);
                    state_q      <= StWr;
                end
                StWr: begin
                    if (!fb_waitrequest) begin
                        fb_write <= 1'b0;
                        if (px_last) begin
                            state_q <= StNext;
                        end else begin
                            cam_read <= 1'b1;
                            state_q  <= StRd;
                        end
                    end
                end
                StNext: begin
                    if (last_line) begin
                        // done/busy change together with the disarm write.
                        busy          <= 1'b0;
                        done          <= 1'b1;
                        cam_write     <= 1'b1;
                        cam_writedata <= 32'd0;
                        state_q       <= StDisarm;
                    end else begin
                        cam_read <= 1'b1;
                        state_q  <= StPoll;
                    end
                end
                StDisarm: state_q <= StIdle;
                default:  state_q <= StIdle;
            endcase
        end
    end

    // Bus addresses are only non-zero in the states that strobe them.
    always_comb begin
        case (state_q)
            StArm, StDisarm: cam_address = CTRL_ADDR;
            StPoll:          cam_address = STATUS_ADDR;
            StRd:            cam_address = buf_addr;
            default:         cam_address = 11'd0;
        endcase
        fb_address = (state_q == StWr) ? fb_addr : 32'd0;
    end

`ifdef CAM_LINE_DMA_OVERRUN_EN
    logic        overrun;
    logic [10:0] skipped;
    logic [16:0] ovr_sum;

    // Lines skipped when hcnt advanced by more than one since the last poll.
    always_comb begin
        overrun = ({1'b0, hcnt} > ({1'b0, last_hcnt_q} + 11'd1));
        skipped = {1'b0, hcnt} - {1'b0, last_hcnt_q} - 11'd1;
        ovr_sum = {1'b0, overrun_count} + {6'd0, skipped};
    end

    // Saturating overrun accumulator, cleared per frame.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overrun_count <= 16'd0;
        end else if (frame_start) begin
            overrun_count <= 16'd0;
        end else if (evt_take && overrun) begin
            overrun_count <= ovr_sum[16] ? 16'hFFFF : ovr_sum[15:0];
        end
    end
`endif

endmodule
